// File: rtl/encoder_request_arbiter_pkg.sv
// Shared definitions for the encoder request arbiter: FSM state encoding and default sizing.
package encoder_request_arbiter_pkg;

   localparam int ARB_N_REQ_DEF    = 10;
   localparam int ARB_ID_W_DEF     = 4;
   localparam int ARB_MAX_HOLD_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/encoder_request_arbiter_pick.sv
// Combinational winner picker: highest eligible index wins, or a rotating descending search
// starting just below the previous winner when ARB_ROUND_ROBIN_EN is defined.
module arb_priority_pick
   import encoder_request_arbiter_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ_DEF,
   parameter int ID_W  = ARB_ID_W_DEF
) (
   input  logic [N_REQ-1:0] elig,
   input  logic [ID_W-1:0]  base,
   output logic [N_REQ-1:0] onehot,
   output logic [ID_W-1:0]  id,
   output logic             any
);

`ifdef ARB_ROUND_ROBIN_EN
   // Walk from lowest to highest priority so the last hit (base-1, wrapping) wins.
   always_comb begin
      int idx;
      idx    = 0;
      onehot = '0;
      id     = '0;
      any    = |elig;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = (int'(base) + 2 * N_REQ - 1 - k) % N_REQ;
         if (elig[idx]) begin
            onehot      = '0;
            onehot[idx] = 1'b1;
            id          = ID_W'(idx);
         end
      end
   end
`else
   logic unused_base;
   assign unused_base = ^base;

   always_comb begin
      onehot = '0;
      id     = '0;
      any    = |elig;
      for (int i = 0; i < N_REQ; i++) begin
         if (elig[i]) begin
            onehot    = '0;
            onehot[i] = 1'b1;
            id        = ID_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/encoder_request_arbiter.sv
// Grant FSM sharing one resource among N_REQ requesters with hold timeout and block mask.
// Optional rotating priority is selected with the ARB_ROUND_ROBIN_EN macro.
module encoder_request_arbiter
   import encoder_request_arbiter_pkg::*;
#(
   parameter int N_REQ    = ARB_N_REQ_DEF,
   parameter int ID_W     = ARB_ID_W_DEF,
   parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id,
   output logic             grant_valid,
   output logic             timeout
);

   localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   arb_state_t        state, state_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
   logic [ID_W-1:0]   last_id, last_id_nxt;
   logic [N_REQ-1:0]  block, block_nxt;
   logic [N_REQ-1:0]  grant_nxt;
   logic [ID_W-1:0]   grant_id_nxt;
   logic              timeout_nxt;

   logic [N_REQ-1:0]  elig;
   logic [N_REQ-1:0]  win_onehot;
   logic [ID_W-1:0]   win_id;
   logic              win_any;
   logic              owner_req;

   assign elig      = req & ~block;
   assign owner_req = |(req & grant);

   arb_priority_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_pick (
      .elig   (elig),
      .base   (last_id),
      .onehot (win_onehot),
      .id     (win_id),
      .any    (win_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         last_id     <= '0;
         block       <= '0;
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_cnt_nxt;
         last_id     <= last_id_nxt;
         block       <= block_nxt;
         grant       <= grant_nxt;
         grant_id    <= grant_id_nxt;
         grant_valid <= |grant_nxt;
         timeout     <= timeout_nxt;
      end
   end

   // A block bit survives only while its requester keeps asking.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      last_id_nxt  = last_id;
      block_nxt    = block & req;
      grant_nxt    = grant;
      grant_id_nxt = grant_id;
      timeout_nxt  = 1'b0;

      case (state)
         IDLE: begin
            if (en && win_any) begin
               grant_nxt    = win_onehot;
               grant_id_nxt = win_id;
               last_id_nxt  = win_id;
               hold_cnt_nxt = '0;
               state_nxt    = GRANT;
            end
         end
         GRANT: begin
            if (!owner_req) begin
               grant_nxt    = '0;
               grant_id_nxt = '0;
               state_nxt    = GAP;
            end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
               grant_nxt    = '0;
               grant_id_nxt = '0;
               timeout_nxt  = 1'b1;
               block_nxt    = (block & req) | grant;
               state_nxt    = GAP;
            end else if (hold_cnt != HOLD_LAST) begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         GAP: begin
            hold_cnt_nxt = '0;
            state_nxt    = IDLE;
         end
         default: begin
            grant_nxt    = '0;
            grant_id_nxt = '0;
            hold_cnt_nxt = '0;
            state_nxt    = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_encoder_request_arbiter.sv
// Directed self-checking bench for encoder_request_arbiter, built with MAX_HOLD=4.
module tb_encoder_request_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [9:0] req;
   logic [9:0] grant;
   logic [3:0] grant_id;
   logic       grant_valid;
   logic       timeout;

   int checks = 0;
   int fails  = 0;

   encoder_request_arbiter #(
      .N_REQ    (10),
      .ID_W     (4),
      .MAX_HOLD (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .req         (req),
      .grant       (grant),
      .grant_id    (grant_id),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   task automatic applyStimulus(input logic r, input logic e, input logic [9:0] q);
      rst = r;
      en  = e;
      req = q;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [9:0] eg, input logic [3:0] eid,
                              input logic ev, input logic et);
      logic [15:0] obs;
      logic [15:0] exp;
      obs = {grant, grant_id, grant_valid, timeout};
      exp = {eg, eid, ev, et};
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: grant=%b id=%0d valid=%b timeout=%b, expected grant=%b id=%0d valid=%b timeout=%b",
                tag, grant, grant_id, grant_valid, timeout, eg, eid, ev, et);
      end
   endtask

   initial begin
      logic [3:0] rr_exp [4];
      logic [9:0] drop;
`ifdef ARB_ROUND_ROBIN_EN
      rr_exp = '{4'd9, 4'd0, 4'd9, 4'd0};
`else
      rr_exp = '{4'd9, 4'd9, 4'd9, 4'd9};
`endif
      rst = 1'b1;
      en  = 1'b0;
      req = '0;

      // Reset state
      applyStimulus(1'b1, 1'b0, 10'h000);
      applyStimulus(1'b1, 1'b0, 10'h000);
      checkOutput("reset", 10'h000, 4'd0, 1'b0, 1'b0);

      // Highest index wins, one cycle latency
      applyStimulus(1'b0, 1'b1, 10'b0000100001);
      checkOutput("first_grant", 10'b0000100000, 4'd5, 1'b1, 1'b0);

      // Owner 5 releases, two dead cycles, then requester 0
      applyStimulus(1'b0, 1'b1, 10'b0000000001);
      checkOutput("release_edge", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'b0000000001);
      checkOutput("gap_cycle", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'b0000000001);
      checkOutput("grant_0", 10'b0000000001, 4'd0, 1'b1, 1'b0);

      // en gating
      applyStimulus(1'b0, 1'b0, 10'h000);
      applyStimulus(1'b0, 1'b0, 10'h000);
      applyStimulus(1'b0, 1'b0, 10'h3FF);
      checkOutput("en_low_a", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 10'h3FF);
      checkOutput("en_low_b", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h3FF);
      checkOutput("en_high_9", 10'h200, 4'd9, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 10'h3FF);
      checkOutput("en_drop_hold_a", 10'h200, 4'd9, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 10'h3FF);
      checkOutput("en_drop_hold_b", 10'h200, 4'd9, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h000);
      checkOutput("release_9", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h000);

      // Timeout after 4 cycles of ownership
      applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("to_grant", 10'h008, 4'd3, 1'b1, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         applyStimulus(1'b0, 1'b1, 10'h008);
         checkOutput($sformatf("to_hold_%0d", c), 10'h008, 4'd3, 1'b1, 1'b0);
      end
      applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("to_pulse", 10'h000, 4'd0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("to_pulse_end", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("blocked_a", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("blocked_b", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h000);
      applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("unblocked", 10'h008, 4'd3, 1'b1, 1'b0);

      // Release on the same edge the timeout would fire: no pulse, no block
      for (int c = 1; c <= 3; c++) applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("last_hold", 10'h008, 4'd3, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h000);
      checkOutput("release_at_limit", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h008);
      applyStimulus(1'b0, 1'b1, 10'h008);
      checkOutput("not_blocked", 10'h008, 4'd3, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h000);
      applyStimulus(1'b0, 1'b1, 10'h000);

      // Alternating owners; ordering depends on the priority mode
      applyStimulus(1'b1, 1'b0, 10'h000);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 1'b1, 10'h201);
         checkOutput($sformatf("rr_%0d", k), 10'h001 << rr_exp[k], rr_exp[k], 1'b1, 1'b0);
         drop = 10'h201 & ~(10'h001 << rr_exp[k]);
         applyStimulus(1'b0, 1'b1, drop);
         applyStimulus(1'b0, 1'b1, 10'h201);
      end
      applyStimulus(1'b0, 1'b1, 10'h000);
      applyStimulus(1'b0, 1'b1, 10'h000);
      applyStimulus(1'b0, 1'b1, 10'h000);

      // Reset mid-grant
      applyStimulus(1'b0, 1'b1, 10'h080);
      checkOutput("grant_7", 10'h080, 4'd7, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 10'h080);
      checkOutput("reset_mid_grant", 10'h000, 4'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 10'h090);
      checkOutput("post_reset_grant", 10'h080, 4'd7, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule

// File: doc/encoder_request_arbiter.md
Name: encoder_request_arbiter

Overview:
- Sequential arbiter that shares one downstream resource among 10 requesters.
- Picks a winner with priority-encoder semantics (highest index wins by default) and issues a one-hot grant plus a 4-bit encoded grant ID.
- Holds the grant until the owner releases it or a hold timeout expires.
- Sits between the requester bank and the shared datapath; grant_id drives the datapath mux select.

Parameters:
- N_REQ, 10, number of requesters (2..16).
- ID_W, 4, width of grant_id; must satisfy 2**ID_W >= N_REQ.
- MAX_HOLD, 16, maximum cycles one grant may last; 0 disables the timeout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; gates new grants only.
- req  input  N_REQ  request vector; requester i holds req[i] high for as long as it uses the resource.
- grant  output  N_REQ  one-hot grant, registered; all-zero when no owner.
- grant_id  output  ID_W  index of the current owner, registered; 0 when no owner.
- grant_valid  output  1  high exactly while grant is non-zero.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (rst high at a clock edge):
  - Outputs: grant=0, grant_id=0, grant_valid=0, timeout=0.
  - Internal state: state=IDLE, hold_cnt=0, last_id=0, block mask=0.
  - Reset has priority over every other event and takes effect on the next edge, including mid-grant.
- Eligible requests: elig = req & ~block.
- State IDLE:
  - If en=1 and |elig at an edge, the winner is registered at that same edge and the state goes to GRANT.
  - Latency is 1 cycle from req being sampled to grant being visible.
  - If en=0 or elig=0, the block stays in IDLE.
- Winner selection (default): highest set index of elig, so bit 9 beats bit 0 (same ordering as the 10-to-4 priority encoder).
- State GRANT:
  - hold_cnt increments each cycle and saturates at MAX_HOLD-1.
  - If req[grant_id]=0 at an edge: grant, grant_id and grant_valid clear at that edge; go to GAP.
  - Else if MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1:
    - grant clears and timeout=1 for one cycle;
    - block[grant_id] is set;
    - go to GAP.
  - Otherwise hold the grant; changes on other req bits are ignored.
- State GAP:
  - One dead cycle with grant=0 and hold_cnt reset; always returns to IDLE.
  - Back-to-back grants are therefore separated by at least 2 cycles of grant=0.
- Block mask: block[i] clears on any edge where req[i]=0. A timed-out requester must drop its request before it can win again.
- last_id updates to the winner at every grant.
- en=0 during GRANT does not preempt the current owner; no new grant is issued until en=1.
- If the owner drops req on the same edge that the timeout would fire, this counts as a normal release: no timeout pulse and no block.
- MAX_HOLD=1: a grant lasts exactly 1 cycle, then times out unless req was already released.
- req bits at index >= N_REQ do not exist. grant_id is always < N_REQ.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- When defined:
  - Rotating priority; the search descends from index (last_id-1) mod N_REQ with wrap-around.
  - The most recently granted requester has the lowest priority.
  - After reset last_id=0, so index N_REQ-1 has top priority on the first arbitration.
- When undefined: fixed priority, highest index wins; last_id is still kept but not used for selection.

Decomposition:
- Shared include file:
  - state encodings IDLE=2'd0, GRANT=2'd1, GAP=2'd2;
  - default parameter values.
- Sub-module arb_priority_pick: purely combinational.
  - Inputs: elig vector and rotation base.
  - Outputs: one-hot winner, encoded ID and any-valid.
  - Rotation logic is compiled in only under ARB_ROUND_ROBIN_EN.
- The top level holds the FSM, hold counter, block mask and output registers.

Test Plan:
- Reset then req=10'b0000100001, en=1 -> after 1 edge grant=10'b0000100000, grant_id=5, grant_valid=1.
- Owner 5 drops req while req[0] is held -> grant=0 for 2 cycles (release edge + GAP), then grant_id=0.
- en=0 with req=10'h3FF -> grant stays 0. Raise en -> grant_id=9. Drop en mid-grant -> grant to 9 persists.
- MAX_HOLD=4, req[3] held high -> grant_valid high for exactly 4 cycles, then timeout pulse=1 for 1 cycle.
  - req[3] is not re-granted while it stays high.
  - Drop req[3] for 1 cycle and re-raise -> it is granted again.
- ARB_ROUND_ROBIN_EN, req=10'b1000000001 held with owners releasing every 3 cycles -> grant_id sequence 9,0,9,0.
  - Without the macro the sequence is 9,9,9.
- Assert rst during GRANT to 7 -> next edge grant=0, grant_id=0, timeout=0. The first grant after reset follows default priority.
